uart_tx: RTL

Serial transmitter matching the system's UART receiver framing. It accepts one 8-bit parallel word per handshake and shifts it out on `TX_OUT`, LSB first, as one frame: start bit, data bits, an optional even/odd parity bit, and one stop bit. Each bit lasts a programmable number of clocks (`Prescale`). The block sits on the transmit side of the UART, in the same clock domain as its data source.

---
 rtl/uart_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART serial transmitter, LSB first.
// Frame: start bit, 8 data bits, an optional parity bit and one stop bit.
// Each bit lasts Prescale clocks; a Prescale of 0 is treated as 1.
// Optional feature macro: UART_TX_PARITY_EN compiles in the parity bit and the
// PARITY state. Without it, PAR_EN and PAR_TYP are ignored and every frame is
// 10 bit periods long.
module uart_tx (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [4:0] Prescale,
  output logic       TX_OUT,
  output logic       busy
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [4:0] presc_q, presc_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       bit_end_s;

`ifdef UART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
`else
  // Parity inputs are accepted but have no function in this build.
  logic       unused_par_s;
  assign unused_par_s = PAR_EN ^ PAR_TYP;
`endif

  // A bit period ends on the last count of the latched prescale.
  assign bit_end_s = (cnt_q == (presc_q - 5'd1));

  // State, frame latches and registered line outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      idx_q     <= 3'd0;
      data_q    <= 8'd0;
      presc_q   <= 5'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      presc_q   <= presc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // Next-state logic; the line value for the coming cycle is computed here
  // so TX_OUT and busy leave straight from flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    presc_d   = presc_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d   = START;
          data_d    = P_DATA;
          presc_d   = (Prescale == 5'd0) ? 5'd1 : Prescale;
`ifdef UART_TX_PARITY_EN
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
`endif
          cnt_d     = 5'd0;
          idx_d     = 3'd0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          tx_d      = 1'b1;
          busy_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_d   = 5'd0;
          idx_d   = 3'd0;
          state_d = DATA;
          tx_d    = data_q[0];
        end else begin
          cnt_d   = cnt_q + 5'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = 5'd0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          cnt_d   = 5'd0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 5'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          cnt_d   = 5'd0;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
